complex_matmul_stream: RTL



---
 rtl/cmatmul_pkg.sv | 16 +
 rtl/complex_matmul_stream_lane.sv | 44 ++++
 rtl/complex_matmul_stream.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cmatmul_pkg.sv
// cmatmul_pkg: FSM states, default complex widths and re/im field helpers
package cmatmul_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DRAIN} state_t;
  localparam int SIZE_DEF = 16;
  localparam int RW_DEF = 3 * SIZE_DEF;
  localparam int FW = 128;
  // Sign-extends the low half of a w-bit complex word (the real part).
  function automatic logic signed [63:0] re_of(input logic [FW-1:0] v, input int w);
    logic [FW-1:0] t;
    t = v << (FW - w / 2);
    return 64'($signed(t) >>> (FW - w / 2));
  endfunction
  function automatic logic signed [63:0] im_of(input logic [FW-1:0] v, input int w);
    return re_of(v >> (w / 2), w);
  endfunction
endpackage

// File: rtl/complex_matmul_stream_lane.sv
// cplx_mul_pipe: one complex-multiply lane, optional conj(b), LAT-deep pipeline with valid shift
module cplx_mul_pipe
  import cmatmul_pkg::*;
#(
  parameter int SIZE = SIZE_DEF,
  parameter int RW = RW_DEF,
  parameter int LAT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            conj,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            out_valid,
  output logic [RW-1:0]   out_data
);
  localparam int RH = RW / 2;
  logic signed [RH-1:0] ar, ai, br, bi, re, im;
  logic [RW-1:0] pipe [LAT];
  logic [LAT-1:0] vld;
  // Operands are widened to RH first, so products wrap exactly like the sums do.
  always_comb begin
    ar = RH'(re_of(FW'(a), SIZE));
    ai = RH'(im_of(FW'(a), SIZE));
    br = RH'(re_of(FW'(b), SIZE));
    bi = conj ? -RH'(im_of(FW'(b), SIZE)) : RH'(im_of(FW'(b), SIZE));
    re = ar * br - ai * bi;
    im = ar * bi + ai * br;
  end
  always_ff @(posedge clk) begin
    pipe[0] <= {im, re};
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  always_ff @(posedge clk) begin
    if (rst) vld <= '0;
    else begin
      vld[0] <= in_valid;
      for (int k = 1; k < LAT; k++) vld[k] <= vld[k-1];
    end
  end
  assign out_valid = vld[LAT-1];
  assign out_data = pipe[LAT-1];
endmodule

// File: rtl/complex_matmul_stream.sv
// complex_matmul_stream: streams in A and B, issues one C element per cycle over A_COL lanes
module complex_matmul_stream
  import cmatmul_pkg::*;
#(
  parameter int A_ROW = 2,
  parameter int A_COL = 2,
  parameter int B_COL = 2,
  parameter int SIZE = SIZE_DEF,
  parameter int LAT = 3,
  parameter int RW = 3 * SIZE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     conj_b,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [SIZE-1:0]          a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [SIZE-1:0]          b_data,
  output logic                     res_valid,
  output logic [RW-1:0]            res_data,
  output logic [$clog2(A_ROW)-1:0] res_row,
  output logic [$clog2(B_COL)-1:0] res_col,
  output logic                     busy,
  output logic                     done
);
  localparam int RH = RW / 2;
  localparam int NA = A_ROW * A_COL;
  localparam int NB = A_COL * B_COL;
  localparam int RRW = $clog2(A_ROW);
  localparam int CCW = $clog2(B_COL);
  localparam int AKW = $clog2(NA + 1);
  localparam int BKW = $clog2(NB + 1);
  localparam int AIW = NA > 1 ? $clog2(NA) : 1;
  localparam int BIW = NB > 1 ? $clog2(NB) : 1;
  state_t state, state_n;
  logic [SIZE-1:0] a_mem [NA];
  logic [SIZE-1:0] b_mem [NB];
  logic [AKW-1:0] a_cnt;
  logic [BKW-1:0] b_cnt;
  logic [RRW-1:0] i_idx;
  logic [CCW-1:0] j_idx;
  logic [RRW-1:0] row_pipe [LAT];
  logic [CCW-1:0] col_pipe [LAT];
  logic [A_COL-1:0] lane_v;
  logic [RW-1:0] lane_d [A_COL];
  logic signed [RH-1:0] sum_re, sum_im;
  logic conj_q, a_acc, b_acc, a_full_n, b_full_n, issue, col_last, last_issue, all_v;
  assign a_ready = state == LOAD && a_cnt != AKW'(NA);
  assign b_ready = state == LOAD && b_cnt != BKW'(NB);
  assign busy = state != IDLE;
  assign a_acc = a_valid && a_ready;
  assign b_acc = b_valid && b_ready;
  assign a_full_n = a_cnt + AKW'(a_acc) == AKW'(NA);
  assign b_full_n = b_cnt + BKW'(b_acc) == BKW'(NB);
  assign issue = state == ISSUE;
  assign col_last = j_idx == CCW'(B_COL - 1);
  assign last_issue = col_last && i_idx == RRW'(A_ROW - 1);
  assign all_v = &lane_v;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? LOAD : IDLE;
      LOAD:    state_n = a_full_n && b_full_n ? ISSUE : LOAD;
      ISSUE:   state_n = last_issue ? DRAIN : ISSUE;
      DRAIN:   state_n = done ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_cnt <= '0;
      b_cnt <= '0;
      i_idx <= '0;
      j_idx <= '0;
      conj_q <= 1'b0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_row <= '0;
      res_col <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        conj_q <= conj_b;
        a_cnt <= '0;
        b_cnt <= '0;
        i_idx <= '0;
        j_idx <= '0;
      end
      if (a_acc) a_cnt <= a_cnt + AKW'(1);
      if (b_acc) b_cnt <= b_cnt + BKW'(1);
      if (issue) begin
        j_idx <= col_last ? '0 : j_idx + CCW'(1);
        if (col_last) i_idx <= last_issue ? '0 : i_idx + RRW'(1);
      end
      res_valid <= all_v;
      if (all_v) begin
        res_data <= {sum_im, sum_re};
        res_row <= row_pipe[LAT-1];
        res_col <= col_pipe[LAT-1];
      end
      done <= all_v && row_pipe[LAT-1] == RRW'(A_ROW - 1) && col_pipe[LAT-1] == CCW'(B_COL - 1);
    end
  end
  // Operand storage and the (row, col) tags travelling alongside the lane pipelines.
  always_ff @(posedge clk) begin
    if (a_acc) a_mem[AIW'(a_cnt)] <= a_data;
    if (b_acc) b_mem[BIW'(b_cnt)] <= b_data;
    row_pipe[0] <= i_idx;
    col_pipe[0] <= j_idx;
    for (int k = 1; k < LAT; k++) begin
      row_pipe[k] <= row_pipe[k-1];
      col_pipe[k] <= col_pipe[k-1];
    end
  end
  for (genvar k = 0; k < A_COL; k++) begin : g_lane
    cplx_mul_pipe #(.SIZE(SIZE), .RW(RW), .LAT(LAT)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .in_valid (issue),
      .conj     (conj_q),
      .a        (a_mem[AIW'(int'(i_idx) * A_COL + k)]),
      .b        (b_mem[BIW'(k * B_COL + int'(j_idx))]),
      .out_valid(lane_v[k]),
      .out_data (lane_d[k])
    );
  end
  always_comb begin
    sum_re = '0;
    sum_im = '0;
    for (int k = 0; k < A_COL; k++) begin
      sum_re = sum_re + RH'(re_of(FW'(lane_d[k]), RW));
      sum_im = sum_im + RH'(im_of(FW'(lane_d[k]), RW));
    end
  end
endmodule
